// File: rtl/reg_writeback.sv
// Write-back controller: one-entry buffers for ALU and load results, round-robin
// commit to the register file write port, and a pending-write scoreboard. Option: REG0_ZERO_EN.
module reg_writeback #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  localparam int NREGS = 2**REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_wreg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_wreg,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_wreg,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wreg,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREGS-1:0]  busy
);

  // Handshake: a result transfers on a rising edge where x_valid & x_ready are both 1;
  // x_ready also rises in the cycle the held entry is being granted (pass-through refill).
  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_e;

  logic              alu_full_q, alu_full_d, ld_full_q, ld_full_d;
  logic [REG_AW-1:0] alu_wreg_q, alu_wreg_d, ld_wreg_q, ld_wreg_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d, ld_data_q, ld_data_d;
  src_e              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_wreg_q, rf_wreg_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]  busy_q, busy_d;

  logic              alu_gnt, ld_gnt, alu_hs, ld_hs;
  logic [REG_AW-1:0] gnt_wreg;
  logic [DATA_W-1:0] gnt_data;
  logic              commit_ok;

  always_comb begin
    // On a tie the source that did not win last time is served.
    alu_gnt   = alu_full_q & (~ld_full_q | (last_grant_q == SRC_LD));
    ld_gnt    = ld_full_q & (~alu_full_q | (last_grant_q == SRC_ALU));
    alu_ready = ~alu_full_q | alu_gnt;
    ld_ready  = ~ld_full_q | ld_gnt;
    alu_hs    = alu_valid & alu_ready;
    ld_hs     = ld_valid & ld_ready;
    gnt_wreg  = ld_gnt ? ld_wreg_q : alu_wreg_q;
    gnt_data  = ld_gnt ? ld_data_q : alu_data_q;
`ifdef REG0_ZERO_EN
    commit_ok = (alu_gnt | ld_gnt) & (gnt_wreg != '0);
`else
    commit_ok = alu_gnt | ld_gnt;
`endif
  end

  always_comb begin
    alu_full_d   = alu_full_q;
    alu_wreg_d   = alu_wreg_q;
    alu_data_d   = alu_data_q;
    ld_full_d    = ld_full_q;
    ld_wreg_d    = ld_wreg_q;
    ld_data_d    = ld_data_q;
    last_grant_d = last_grant_q;
    rf_we_d      = commit_ok;
    rf_wreg_d    = rf_wreg_q;
    rf_wdata_d   = rf_wdata_q;
    busy_d       = busy_q;

    if (alu_hs) begin
      alu_full_d = 1'b1;
      alu_wreg_d = alu_wreg;
      alu_data_d = alu_data;
    end else if (alu_gnt) begin
      alu_full_d = 1'b0;
    end

    if (ld_hs) begin
      ld_full_d = 1'b1;
      ld_wreg_d = ld_wreg;
      ld_data_d = ld_data;
    end else if (ld_gnt) begin
      ld_full_d = 1'b0;
    end

    if (alu_gnt) last_grant_d = SRC_ALU;
    else if (ld_gnt) last_grant_d = SRC_LD;

    if (commit_ok) begin
      rf_wreg_d  = gnt_wreg;
      rf_wdata_d = gnt_data;
    end

    // Set is applied after clear so a new producer wins over a retiring one.
    if (rf_we_q) busy_d[rf_wreg_q] = 1'b0;
    if (iss_valid) busy_d[iss_wreg] = 1'b1;
`ifdef REG0_ZERO_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full_q   <= 1'b0;
      alu_wreg_q   <= '0;
      alu_data_q   <= '0;
      ld_full_q    <= 1'b0;
      ld_wreg_q    <= '0;
      ld_data_q    <= '0;
      last_grant_q <= SRC_ALU;
      rf_we_q      <= 1'b0;
      rf_wreg_q    <= '0;
      rf_wdata_q   <= '0;
      busy_q       <= '0;
    end else begin
      alu_full_q   <= alu_full_d;
      alu_wreg_q   <= alu_wreg_d;
      alu_data_q   <= alu_data_d;
      ld_full_q    <= ld_full_d;
      ld_wreg_q    <= ld_wreg_d;
      ld_data_q    <= ld_data_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_wreg_q    <= rf_wreg_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wreg  = rf_wreg_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-based reference model, directed scenarios plus random
// traffic, and a monitor that pops expected commits whenever rf_we is seen.
module tb_reg_writeback;

  logic        clk, rst_n;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, iss_valid, rf_we;
  logic [2:0]  alu_wreg, ld_wreg, iss_wreg, rf_wreg;
  logic [15:0] alu_data, ld_data, rf_wdata;
  logic [7:0]  busy;

  reg_writeback #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wreg(alu_wreg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wreg(ld_wreg), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_wreg(iss_wreg),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  w;
    logic [15:0] d;
  } ent_t;

  int checks = 0;
  int failures = 0;

  // reference model: pending results per source, commit stream, scoreboard
  ent_t        aq[$], lq[$];
  logic [18:0] exp_q[$];
  logic        m_last;      // 0: ALU won last, 1: load won last
  logic        m_we;
  logic [2:0]  m_wreg;
  logic [7:0]  m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reg_dropped(input logic [2:0] w);
`ifdef REG0_ZERO_EN
    return w == 3'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    aq.delete();
    lq.delete();
    exp_q.delete();
    m_last = 1'b0;
    m_we   = 1'b0;
    m_wreg = 3'd0;
    m_busy = 8'h00;
  endtask

  // one clock of stimulus; checks ready, rf_we and busy against the model
  task automatic step(input logic av, input logic [2:0] aw, input logic [15:0] ad,
                      input logic lv, input logic [2:0] lw, input logic [15:0] ld,
                      input logic iv, input logic [2:0] iw);
    logic ag, lg;
    ent_t e;
    logic [7:0] nb;
    @(negedge clk);
    alu_valid = av; alu_wreg = aw; alu_data = ad;
    ld_valid = lv;  ld_wreg = lw;  ld_data = ld;
    iss_valid = iv; iss_wreg = iw;
    #1;
    ag = (aq.size() != 0) && ((lq.size() == 0) || m_last);
    lg = (lq.size() != 0) && ((aq.size() == 0) || !m_last);
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, (aq.size() == 0) || ag});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, (lq.size() == 0) || lg});
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("busy", {24'd0, busy}, {24'd0, m_busy});
    @(posedge clk);
    nb = m_busy;
    if (m_we) nb[m_wreg] = 1'b0;
    if (iv && !reg_dropped(iw)) nb[iw] = 1'b1;
    m_busy = nb;
    m_we = 1'b0;
    if (ag || lg) begin
      e = ag ? aq.pop_front() : lq.pop_front();
      m_last = lg;
      if (!reg_dropped(e.w)) begin
        m_we = 1'b1;
        m_wreg = e.w;
        exp_q.push_back({e.w, e.d});
      end
    end
    if (av && aq.size() == 0) aq.push_back('{w: aw, d: ad});
    if (lv && lq.size() == 0) lq.push_back('{w: lw, d: ld});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    alu_valid = 0; ld_valid = 0; iss_valid = 0;
    rst_n = 1'b0;
    #2;
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset busy", {24'd0, busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("post-reset alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("post-reset ld_ready", {31'd0, ld_ready}, 32'd1);
  endtask

  // monitor: every observed commit must match the head of the expected stream
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected commit", {13'd0, rf_wreg, rf_wdata}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("commit", {13'd0, rf_wreg, rf_wdata}, {13'd0, e});
      end
    end
  end

  initial begin
    alu_valid = 0; alu_wreg = 0; alu_data = 0;
    ld_valid = 0;  ld_wreg = 0;  ld_data = 0;
    iss_valid = 0; iss_wreg = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset rf_wreg", {29'd0, rf_wreg}, 32'd0);
    chk("reset rf_wdata", {16'd0, rf_wdata}, 32'd0);
    chk("reset busy", {24'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // single ALU write to r3
    step(0, 0, 0, 0, 0, 0, 1, 3);
    step(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    idle(3);

    // contention: load wins the first tie, then strict alternation
    for (int i = 0; i < 8; i++) step(1, 2, 16'h0055, 1, 1, 16'h00AA, 0, 0);
    idle(3);

    // backpressure: load held valid while ALU keeps refilling and competing
    for (int i = 0; i < 4; i++) step(1, 4, 16'h0100 + 16'(i), 1, 6, 16'h0200 + 16'(i), 0, 0);
    idle(4);

    // set/clear collision on r5
    step(0, 0, 0, 0, 0, 0, 1, 5);
    step(1, 5, 16'h5555, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5);
    idle(2);
    chk("busy5 after collision", {31'd0, busy[5]}, 32'd1);

    // register 0 write
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    idle(3);

    // random traffic, reset dropped in mid-stream
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 99) < 30), 3'($urandom_range(0, 7)));
    end
    idle(5);
    chk("pending commits drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
